point_ram_loader: RTL and testbench

Host-side writer for the k-means point RAM. It accepts a valid/ready stream of points and writes them into consecutive RAM addresses through the active-low RAM pins (CSB/WEB/OEB). It then publishes `first_ram_addr`/`last_ram_addr`, pulses `go` to the k-means controller, and holds RAM ownership released until the controller raises `interupt`. It sits between the host bus and the shared RAM mux, in front of the controller's read path.

---
 rtl/point_ram_loader.sv | 179 +++++++++++++++++
 tb/tb_point_ram_loader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/point_ram_loader.sv
// Host-side point RAM writer: streams points into consecutive RAM words, then hands
// the RAM to the k-means controller with a go pulse and waits for its interrupt.
module point_ram_loader #(
    parameter int unsigned log2_of_point_cnt = 9,
    parameter int unsigned ram_word_len      = 50
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_start,
    input  logic [log2_of_point_cnt-1:0] base_addr,
    input  logic                         point_valid,
    input  logic [ram_word_len-1:0]      point_data,
    input  logic                         point_last,
    output logic                         point_ready,
    output logic [log2_of_point_cnt-1:0] ram_addr,
    output logic [ram_word_len-1:0]      ram_data_in,
    output logic                         wr_en_n,
    output logic                         output_en_n,
    output logic                         chip_select_n,
    output logic                         ram_owner,
    output logic [log2_of_point_cnt-1:0] first_ram_addr,
    output logic [log2_of_point_cnt-1:0] last_ram_addr,
    output logic                         go,
    input  logic                         interupt,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow
);

    localparam int unsigned AW = log2_of_point_cnt;
    localparam int unsigned DW = ram_word_len;
    localparam logic [AW-1:0] ADDR_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_RELEASE   = 3'd2,
        S_START     = 3'd3,
        S_WAIT_CORE = 3'd4
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_wr_ptr;
    logic            r_point_ready;
    logic [AW-1:0]   r_ram_addr;
    logic [DW-1:0]   r_ram_data;
    logic            r_web_n;
    logic            r_csb_n;
    logic            r_ram_owner;
    logic [AW-1:0]   r_first_addr;
    logic [AW-1:0]   r_last_addr;
    logic            r_go;
    logic            r_busy;
    logic            r_done;
    logic            r_overflow;

    state_t          w_state_nxt;
    logic [AW-1:0]   w_wr_ptr;
    logic            w_point_ready;
    logic [AW-1:0]   w_ram_addr;
    logic [DW-1:0]   w_ram_data;
    logic            w_csb_n;
    logic            w_ram_owner;
    logic [AW-1:0]   w_first_addr;
    logic [AW-1:0]   w_last_addr;
    logic            w_go;
    logic            w_busy;
    logic            w_done;
    logic            w_overflow;
    logic            w_hs;

    assign w_hs = point_valid & r_point_ready;

    // Next state plus the next value of every registered output
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr     = r_wr_ptr;
        w_ram_addr   = r_ram_addr;
        w_ram_data   = r_ram_data;
        w_csb_n      = 1'b1;
        w_first_addr = r_first_addr;
        w_last_addr  = r_last_addr;
        w_done       = 1'b0;
        w_overflow   = r_overflow;

        case (r_state)
            S_IDLE: begin
                if (load_start) begin
                    w_wr_ptr     = base_addr;
                    w_first_addr = base_addr;
                    w_overflow   = 1'b0;
                    w_state_nxt  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_hs) begin
                    w_csb_n    = 1'b0;
                    w_ram_addr = r_wr_ptr;
                    w_ram_data = point_data;
                    if (point_last) begin
                        w_last_addr = r_wr_ptr;
                        w_state_nxt = S_RELEASE;
                    end else if (r_wr_ptr == ADDR_MAX) begin
                        // Top of RAM reached without a last marker: stop rather than wrap
                        w_last_addr = ADDR_MAX;
                        w_overflow  = 1'b1;
                        w_state_nxt = S_RELEASE;
                    end else begin
                        w_wr_ptr = r_wr_ptr + AW'(1);
                    end
                end
            end
            S_RELEASE: w_state_nxt = S_START;
            S_START:   w_state_nxt = S_WAIT_CORE;
            S_WAIT_CORE: begin
                if (interupt) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Ownership covers RELEASE so the final write completes before the mux flips
        w_point_ready = (w_state_nxt == S_LOAD);
        w_ram_owner   = (w_state_nxt == S_LOAD) || (w_state_nxt == S_RELEASE);
        w_go          = (w_state_nxt == S_START);
        w_busy        = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_point_ready <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_data    <= '0;
            r_web_n       <= 1'b1;
            r_csb_n       <= 1'b1;
            r_ram_owner   <= 1'b0;
            r_first_addr  <= '0;
            r_last_addr   <= '0;
            r_go          <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wr_ptr      <= w_wr_ptr;
            r_point_ready <= w_point_ready;
            r_ram_addr    <= w_ram_addr;
            r_ram_data    <= w_ram_data;
            r_web_n       <= w_csb_n;
            r_csb_n       <= w_csb_n;
            r_ram_owner   <= w_ram_owner;
            r_first_addr  <= w_first_addr;
            r_last_addr   <= w_last_addr;
            r_go          <= w_go;
            r_busy        <= w_busy;
            r_done        <= w_done;
            r_overflow    <= w_overflow;
        end
    end

    assign point_ready    = r_point_ready;
    assign ram_addr       = r_ram_addr;
    assign ram_data_in    = r_ram_data;
    assign wr_en_n        = r_web_n;
    assign output_en_n    = 1'b1;
    assign chip_select_n  = r_csb_n;
    assign ram_owner      = r_ram_owner;
    assign first_ram_addr = r_first_addr;
    assign last_ram_addr  = r_last_addr;
    assign go             = r_go;
    assign busy           = r_busy;
    assign done           = r_done;
    assign overflow       = r_overflow;

endmodule

// File: tb/tb_point_ram_loader.sv
// Directed bench for point_ram_loader: logs every RAM write cycle and checks
// addresses, data, handshake timing and controller hand-off against fixed expectations.
module tb_point_ram_loader;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 50;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [AW-1:0] base_addr;
    logic          point_valid;
    logic [DW-1:0] point_data;
    logic          point_last;
    logic          point_ready;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data_in;
    logic          wr_en_n;
    logic          output_en_n;
    logic          chip_select_n;
    logic          ram_owner;
    logic [AW-1:0] first_ram_addr;
    logic [AW-1:0] last_ram_addr;
    logic          go;
    logic          interupt;
    logic          busy;
    logic          done;
    logic          overflow;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int go_cnt   = 0;
    int done_cnt = 0;
    bit mon_en   = 1'b0;

    logic [AW-1:0] q_addr[$];
    logic [DW-1:0] q_data[$];
    int            q_cyc[$];
    logic [DW-1:0] exp_d[8];

    point_ram_loader dut (
        .clk(clk), .rst(rst), .load_start(load_start), .base_addr(base_addr),
        .point_valid(point_valid), .point_data(point_data), .point_last(point_last),
        .point_ready(point_ready), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
        .wr_en_n(wr_en_n), .output_en_n(output_en_n), .chip_select_n(chip_select_n),
        .ram_owner(ram_owner), .first_ram_addr(first_ram_addr),
        .last_ram_addr(last_ram_addr), .go(go), .interupt(interupt), .busy(busy),
        .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Write-cycle logger and pin-level invariants, sampled mid-cycle
    always @(negedge clk) begin
        if (mon_en) begin
            if (chip_select_n === 1'b0) begin
                q_addr.push_back(ram_addr);
                q_data.push_back(ram_data_in);
                q_cyc.push_back(cyc);
                check_eq("owner_during_write", 64'(ram_owner), 64'd1);
                check_eq("web_during_write", 64'(wr_en_n), 64'd0);
                check_eq("oeb_during_write", 64'(output_en_n), 64'd1);
            end
            if (go === 1'b1) go_cnt++;
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_test();
        q_addr.delete();
        q_data.delete();
        q_cyc.delete();
        go_cnt   = 0;
        done_cnt = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ready"}, 64'(point_ready), 64'd0);
        check_eq({tag, "_addr"}, 64'(ram_addr), 64'd0);
        check_eq({tag, "_data"}, 64'(ram_data_in), 64'd0);
        check_eq({tag, "_web"}, 64'(wr_en_n), 64'd1);
        check_eq({tag, "_oeb"}, 64'(output_en_n), 64'd1);
        check_eq({tag, "_csb"}, 64'(chip_select_n), 64'd1);
        check_eq({tag, "_owner"}, 64'(ram_owner), 64'd0);
        check_eq({tag, "_first"}, 64'(first_ram_addr), 64'd0);
        check_eq({tag, "_last"}, 64'(last_ram_addr), 64'd0);
        check_eq({tag, "_go"}, 64'(go), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_done"}, 64'(done), 64'd0);
        check_eq({tag, "_ovf"}, 64'(overflow), 64'd0);
    endtask

    task automatic start_load(input logic [AW-1:0] b);
        load_start = 1'b1;
        base_addr  = b;
        tick();
        load_start = 1'b0;
        check_eq("start_ready", 64'(point_ready), 64'd1);
        check_eq("start_busy", 64'(busy), 64'd1);
        check_eq("start_ovf_clr", 64'(overflow), 64'd0);
        check_eq("start_first", 64'(first_ram_addr), 64'(b));
    endtask

    // Offers one point and returns the cycle after its handshake edge
    task automatic push_point(input logic [DW-1:0] d, input logic last);
        int n;
        n = 0;
        point_valid = 1'b1;
        point_data  = d;
        point_last  = last;
        while (point_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_eq("hs_wait", 64'(n < 20), 64'd1);
        tick();
        point_valid = 1'b0;
        point_last  = 1'b0;
    endtask

    task automatic wait_go();
        int n;
        n = 0;
        while (go !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_eq("go_wait", 64'(n < 20), 64'd1);
    endtask

    task automatic finish_core();
        interupt = 1'b1;
        tick();
        interupt = 1'b0;
        check_eq("done_pulse", 64'(done), 64'd1);
        check_eq("done_idle", 64'(busy), 64'd0);
        tick();
        check_eq("done_clear", 64'(done), 64'd0);
    endtask

    task automatic run_core();
        wait_go();
        tick();
        finish_core();
    endtask

    task automatic check_log(input string tag, input logic [AW-1:0] b, input int n);
        check_eq({tag, "_nwr"}, 64'(q_addr.size()), 64'(n));
        for (int i = 0; i < n && i < q_addr.size(); i++) begin
            check_eq({tag, "_waddr"}, 64'(q_addr[i]), 64'(b + AW'(i)));
            check_eq({tag, "_wdata"}, 64'(q_data[i]), 64'(exp_d[i]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load_start = 1'b0; base_addr = '0; point_valid = 1'b0;
        point_data = '0; point_last = 1'b0; interupt = 1'b0;
        for (int i = 0; i < 8; i++) exp_d[i] = 50'h2_AB00_0000_0000 + DW'(i * 50'h1_0101);
        tick();
        tick();
        check_reset_vals("rst");
        rst = 1'b0;
        mon_en = 1'b1;

        // Basic back-to-back load
        new_test();
        start_load(9'h010);
        for (int i = 0; i < 4; i++) push_point(exp_d[i], (i == 3));
        check_eq("basic_rel_ready", 64'(point_ready), 64'd0);
        check_eq("basic_rel_csb", 64'(chip_select_n), 64'd0);
        check_eq("basic_rel_addr", 64'(ram_addr), 64'h013);
        check_eq("basic_rel_owner", 64'(ram_owner), 64'd1);
        tick();
        check_eq("basic_go", 64'(go), 64'd1);
        check_eq("basic_go_owner", 64'(ram_owner), 64'd0);
        check_eq("basic_go_csb", 64'(chip_select_n), 64'd1);
        check_eq("basic_last", 64'(last_ram_addr), 64'h013);
        check_eq("basic_first", 64'(first_ram_addr), 64'h010);
        tick();
        check_eq("basic_go_off", 64'(go), 64'd0);
        check_eq("basic_wait_busy", 64'(busy), 64'd1);
        finish_core();
        check_log("basic", 9'h010, 4);
        if (q_cyc.size() == 4) check_eq("basic_span", 64'(q_cyc[3] - q_cyc[0]), 64'd3);
        check_eq("basic_go_cnt", 64'(go_cnt), 64'd1);
        check_eq("basic_done_cnt", 64'(done_cnt), 64'd1);

        // Bubbles: valid pattern 1,0,0,1,1,0,1(last)
        new_test();
        start_load(9'h100);
        push_point(exp_d[0], 1'b0);
        tick();
        tick();
        push_point(exp_d[1], 1'b0);
        push_point(exp_d[2], 1'b0);
        tick();
        push_point(exp_d[3], 1'b1);
        run_core();
        check_log("bubble", 9'h100, 4);
        if (q_cyc.size() == 4) check_eq("bubble_span", 64'(q_cyc[3] - q_cyc[0]), 64'd6);
        check_eq("bubble_last", 64'(last_ram_addr), 64'h103);

        // Single point
        new_test();
        start_load(9'h0A5);
        push_point(exp_d[0], 1'b1);
        tick();
        check_eq("single_go", 64'(go), 64'd1);
        check_eq("single_first", 64'(first_ram_addr), 64'h0A5);
        check_eq("single_last", 64'(last_ram_addr), 64'h0A5);
        tick();
        finish_core();
        check_log("single", 9'h0A5, 1);

        // Overflow at the top of RAM
        new_test();
        start_load(9'h1FE);
        push_point(exp_d[0], 1'b0);
        push_point(exp_d[1], 1'b0);
        check_eq("ovf_ready_drop", 64'(point_ready), 64'd0);
        check_eq("ovf_flag", 64'(overflow), 64'd1);
        check_eq("ovf_last", 64'(last_ram_addr), 64'h1FF);
        point_valid = 1'b1;
        point_data  = exp_d[2];
        tick();
        check_eq("ovf_go", 64'(go), 64'd1);
        check_eq("ovf_ready_start", 64'(point_ready), 64'd0);
        point_valid = 1'b0;
        run_core();
        check_log("ovf", 9'h1FE, 2);
        check_eq("ovf_sticky", 64'(overflow), 64'd1);

        // Ignored interupt in LOAD and load_start in WAIT_CORE
        new_test();
        start_load(9'h020);
        interupt = 1'b1;
        tick();
        interupt = 1'b0;
        check_eq("ign_int_ready", 64'(point_ready), 64'd1);
        check_eq("ign_int_busy", 64'(busy), 64'd1);
        check_eq("ign_int_done", 64'(done_cnt), 64'd0);
        push_point(exp_d[0], 1'b0);
        push_point(exp_d[1], 1'b1);
        wait_go();
        tick();
        load_start = 1'b1;
        base_addr  = 9'h0FF;
        tick();
        load_start = 1'b0;
        check_eq("ign_ls_busy", 64'(busy), 64'd1);
        check_eq("ign_ls_ready", 64'(point_ready), 64'd0);
        check_eq("ign_ls_owner", 64'(ram_owner), 64'd0);
        check_eq("ign_ls_first", 64'(first_ram_addr), 64'h020);
        check_eq("ign_ls_last", 64'(last_ram_addr), 64'h021);
        finish_core();
        check_eq("ign_done_cnt", 64'(done_cnt), 64'd1);
        check_log("ign", 9'h020, 2);

        // Reset in the middle of a load
        new_test();
        start_load(9'h040);
        push_point(exp_d[0], 1'b0);
        push_point(exp_d[1], 1'b0);
        point_valid = 1'b1;
        point_data  = exp_d[2];
        rst = 1'b1;
        tick();
        rst = 1'b0;
        point_valid = 1'b0;
        check_reset_vals("midrst");
        for (int i = 0; i < 5; i++) tick();
        check_eq("midrst_no_go", 64'(go_cnt), 64'd0);
        check_eq("midrst_idle", 64'(busy), 64'd0);
        check_log("midrst", 9'h040, 2);
        new_test();
        start_load(9'h050);
        push_point(exp_d[0], 1'b1);
        run_core();
        check_log("postrst", 9'h050, 1);
        check_eq("postrst_go_cnt", 64'(go_cnt), 64'd1);
        check_eq("postrst_last", 64'(last_ram_addr), 64'h050);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
